simple_frequency_generator: RTL and testbench

SIMPLE_FREQUENCY_GENERATOR -- requirements
Module: simple_frequency_generator

---
 rtl/simple_frequency_generator_pkg.sv | 15 +
 rtl/seq_divider.sv | 62 ++++++
 rtl/simple_frequency_generator.sv | 104 ++++++++++
 tb/tb_simple_frequency_generator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_frequency_generator_pkg.sv
// Shared types and width helpers for the simple frequency generator.
// The half-period width is sized to hold CLK_FREQ/2, the largest possible HALF.
package simple_frequency_generator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    APPLY
  } state_e;

  function automatic int half_width(input int clk_freq);
    return $clog2(clk_freq / 2 + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, DIVIDEND_W cycles per division.
// done is high during the final step, so quotient is valid from the following cycle.
module seq_divider #(
  parameter int DIVIDEND_W = 9,
  parameter int DIVISOR_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic                  done
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0] rem_q;
  logic [DIVISOR_W-1:0] den_q;
  logic [CW-1:0]        step_q;
  logic                 running_q;
  logic [DIVISOR_W:0]   rem_shift;
  logic [DIVISOR_W:0]   rem_diff;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_shift = {rem_q, quotient[DIVIDEND_W-1]};
    rem_diff  = rem_shift - {1'b0, den_q};
  end

  assign done = running_q && (step_q == '0);

  // NOTE: every register, including the datapath, is reset so an aborted
  // division leaves nothing behind for the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      step_q    <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      rem_q     <= '0;
      den_q     <= divisor;
      step_q    <= CW'(DIVIDEND_W - 1);
      running_q <= 1'b1;
    end else if (running_q) begin
      // A clear sign bit means the trial subtraction fits: keep it, shift in a 1.
      if (!rem_diff[DIVISOR_W]) begin
        rem_q    <= rem_diff[DIVISOR_W-1:0];
        quotient <= (quotient << 1) | DIVIDEND_W'(1);
      end else begin
        rem_q    <= rem_shift[DIVISOR_W-1:0];
        quotient <= quotient << 1;
      end
      step_q <= step_q - CW'(1);
      if (step_q == '0) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/simple_frequency_generator.sv
// Square-wave generator: a load computes HALF = CLK_FREQ/(2*freq) with a sequential
// divider while the old waveform keeps running, then swaps it in without a glitch.
module simple_frequency_generator
  import simple_frequency_generator_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BIT_SIZE = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_SIZE-1:0] freq_set,
  input  logic                load,
  output logic                busy,
  output logic [BIT_SIZE-1:0] freq_active,
  output logic                signal_out
);

  localparam int              HW            = half_width(CLK_FREQ);
  localparam logic [HW-1:0]   HALF_DIVIDEND = HW'(CLK_FREQ / 2);

  state_e              state_q, state_d;
  logic                div_start;
  logic                div_done;
  logic                apply;
  logic [BIT_SIZE-1:0] freq_q;
  logic [HW-1:0]       quotient;
  logic [HW-1:0]       half_q;
  logic [HW-1:0]       count_q;

  seq_divider #(
    .DIVIDEND_W(HW),
    .DIVISOR_W (BIT_SIZE)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(HALF_DIVIDEND),
    .divisor (freq_set),
    .quotient(quotient),
    .done    (div_done)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    apply     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (freq_set == '0) begin
            state_d = APPLY;
          end else begin
            state_d   = DIVIDE;
            div_start = 1'b1;
          end
        end
      end
      DIVIDE: if (div_done) state_d = APPLY;
      APPLY: begin
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (state_q == IDLE && load) freq_q <= freq_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_active <= '0;
      half_q      <= HW'(1);
      count_q     <= '0;
      signal_out  <= 1'b0;
    end else if (apply) begin
      // The level is kept across the swap; only a zero setting forces it low.
      freq_active <= freq_q;
      half_q      <= (freq_q == '0 || quotient == '0) ? HW'(1) : quotient;
      count_q     <= '0;
      if (freq_q == '0) signal_out <= 1'b0;
    end else if (freq_active == '0) begin
      count_q    <= '0;
      signal_out <= 1'b0;
    end else if (count_q == half_q - HW'(1)) begin
      count_q    <= '0;
      signal_out <= ~signal_out;
    end else begin
      count_q <= count_q + HW'(1);
    end
  end

endmodule

// File: tb/tb_simple_frequency_generator.sv
// Bench for simple_frequency_generator at CLK_FREQ=1000 (HW=9): table of loads plus
// hand-written sequences for the live swap, ignored load and mid-divide reset.
module tb_simple_frequency_generator;

  localparam int CLK_FREQ = 1000;
  localparam int BIT_SIZE = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic [BIT_SIZE-1:0] freq_set;
  logic                busy;
  logic [BIT_SIZE-1:0] freq_active;
  logic                signal_out;

  typedef struct {
    logic [BIT_SIZE-1:0] freq;
    int                  half;      // 0 means the output is held low
    int                  busy_len;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  simple_frequency_generator #(
    .CLK_FREQ(CLK_FREQ),
    .BIT_SIZE(BIT_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freq_set   (freq_set),
    .load       (load),
    .busy       (busy),
    .freq_active(freq_active),
    .signal_out (signal_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_load(input logic [BIT_SIZE-1:0] f);
    @(negedge clk);
    freq_set = f;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts busy samples from the current negedge; optionally pulses a second load.
  task automatic count_busy(input int inject_at, input logic [BIT_SIZE-1:0] inj, output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      load = (n == inject_at);
      if (n == inject_at) freq_set = inj;
      n++;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, output bit ok);
    int n = 0;
    while (signal_out !== lvl && n < 3000) begin
      n++;
      @(negedge clk);
    end
    ok = (signal_out === lvl);
  endtask

  task automatic run_length(output int n);
    logic lvl = signal_out;
    n = 0;
    while (signal_out === lvl && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic sync_rising(output bit ok);
    wait_level(1'b0, ok);
    if (ok) wait_level(1'b1, ok);
    if (!ok) check("wave_timeout", 0, 1);
  endtask

  task automatic apply_vec(input vec_t v, input int inject_at, input logic [BIT_SIZE-1:0] inj);
    int   n, hi, lo, seen;
    bit   ok;
    vec_t e;
    sb_q.push_back(v);
    pulse_load(v.freq);
    count_busy(inject_at, inj, n);
    e = sb_q.pop_front();
    check("busy_len", n, e.busy_len);
    check("freq_active", freq_active, e.freq);
    if (e.half == 0) begin
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (signal_out !== 1'b0) seen++;
        @(negedge clk);
      end
      check("held_low", seen, 0);
    end else begin
      sync_rising(ok);
      if (ok) begin
        run_length(hi);
        run_length(lo);
        check("half_high", hi, e.half);
        check("half_low", lo, e.half);
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   ok;
    int   mism, nb, seen, idx;
    logic got[18];
    logic exp_pat[18];
    int   runs[6];

    vecs[0] = '{20'd100,     5,   10};
    vecs[1] = '{20'd250,     2,   10};
    vecs[2] = '{20'd0,       0,   1};
    vecs[3] = '{20'd600,     1,   10};
    vecs[4] = '{20'd7,       71,  10};
    vecs[5] = '{20'd499,     1,   10};
    vecs[6] = '{20'd1,       500, 10};
    vecs[7] = '{20'd1048575, 1,   10};

    rst      = 1'b0;
    load     = 1'b0;
    freq_set = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_freq_active", freq_active, 0);
    check("reset_signal_out", signal_out, 0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (signal_out !== 1'b0) seen++;
      @(negedge clk);
    end
    check("idle_after_reset_low", seen, 0);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], -1, '0);

    // Live swap 100 Hz -> 250 Hz, starting on a rising edge of the old wave.
    apply_vec('{20'd100, 5, 10}, -1, '0);
    sync_rising(ok);
    runs = '{5, 5, 3, 2, 2, 1};
    idx  = 0;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < runs[r]; k++) begin
        exp_pat[idx] = (r % 2 == 0);
        idx++;
      end
    freq_set = 20'd250;
    load     = 1'b1;
    nb       = 0;
    for (int i = 0; i < 18; i++) begin
      got[i] = signal_out;
      if (busy === 1'b1) nb++;
      @(negedge clk);
      load = 1'b0;
    end
    mism = 0;
    for (int i = 0; i < 18; i++) if (got[i] !== exp_pat[i]) mism++;
    check("swap_pattern_mismatches", mism, 0);
    check("swap_busy_len", nb, 10);
    check("swap_freq_active", freq_active, 250);

    // Second load of 50 during DIVIDE must be ignored.
    apply_vec('{20'd30, 16, 10}, 2, 20'd50);

    // Reset in the middle of a division, while the output is high.
    sync_rising(ok);
    freq_set = 20'd250;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_high", signal_out, 1);
    rst = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_freq_active", freq_active, 0);
    check("mid_reset_signal_out", signal_out, 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (signal_out !== 1'b0 || busy !== 1'b0 || freq_active !== '0) seen++;
      @(negedge clk);
    end
    check("post_reset_quiet", seen, 0);
    apply_vec('{20'd100, 5, 10}, -1, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
